// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
//
// Output-side companion of the systolic PE array. When every PE reports
// finish (rising edge of the AND of all finish flags), the whole
// DIMENSION x DIMENSION result matrix is snapshotted into a local buffer and
// then streamed out one word per valid/ready transfer in row-major order.
//
// Ports
//   i_clock    in   1                   rising-edge clock
//   i_reset    in   1                   asynchronous active-low reset
//   i_c        in   CELLS*O_BITS        flat PE results, PE(r,c) at
//                                       [(r*DIMENSION+c)*O_BITS +: O_BITS]
//   i_finish   in   CELLS               per-PE finish flag, bit r*DIMENSION+c
//   o_data     out  O_BITS              current result word (0 when idle)
//   o_row      out  RC_W                row index of o_data
//   o_col      out  RC_W                column index of o_data
//   o_valid    out  1                   word/row/col/last qualifier
//   i_ready    in   1                   consumer accepts when o_valid&&i_ready
//   o_last     out  1                   final word of the matrix
//   o_busy     out  1                   buffer holds undrained data
//   o_overrun  out  1                   sticky: new matrix arrived while busy
//   i_clear    in   1                   synchronous clear of o_overrun
// -----------------------------------------------------------------------------
module systolic_result_drain #(
    parameter  int DIMENSION = 4,
    parameter  int I_BITS    = 8,
    parameter  int O_BITS    = (I_BITS * 2) + $clog2(DIMENSION),
    localparam int CELLS     = DIMENSION * DIMENSION,
    localparam int RC_W      = (DIMENSION > 1) ? $clog2(DIMENSION) : 1,
    localparam int IDX_W     = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [CELLS*O_BITS-1:0]   i_c,
    input  logic [CELLS-1:0]          i_finish,
    output logic [O_BITS-1:0]         o_data,
    output logic [RC_W-1:0]           o_row,
    output logic [RC_W-1:0]           o_col,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    output logic                      o_busy,
    output logic                      o_overrun,
    input  logic                      i_clear
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(DIMENSION - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RC_W-1:0]    row_q, row_d;
    logic [RC_W-1:0]    col_q, col_d;
    logic               overrun_q, overrun_d;
    logic               all_done;
    logic               all_done_q;
    logic               trigger;
    logic               capture;
    logic               send;
    logic               last_word;

    logic [O_BITS-1:0]  buf_mem [CELLS];

    // Capture trigger: rising edge of "all PEs finished". all_done_q powers up
    // high so a finish vector already high when reset releases is ignored;
    // the array has to drop at least one finish bit and raise it again.
    assign all_done = &i_finish;
    assign trigger  = all_done & ~all_done_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            all_done_q <= 1'b1;
        end else begin
            all_done_q <= all_done;
        end
    end

    assign send      = (state_q == SEND);
    assign last_word = send && (idx_q == IDX_LAST);

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic. row/col are tracked as their own counters so no
    // divider is needed for idx/DIMENSION and idx%DIMENSION.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        capture   = 1'b0;

        // Clear is applied first so that a same-cycle overrun set wins.
        if (i_clear) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                // A new matrix while draining is dropped, including one that
                // lands on the final handshake cycle.
                if (trigger) begin
                    overrun_d = 1'b1;
                end
                if (i_ready) begin
                    if (last_word) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == RC_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end
        endcase
    end

    // Result buffer: data only, no reset. Its contents are never observable
    // outside SEND because o_data is gated by o_valid.
    always_ff @(posedge i_clock) begin
        if (capture) begin
            for (int i = 0; i < CELLS; i++) begin
                buf_mem[i] <= i_c[i*O_BITS +: O_BITS];
            end
        end
    end

    assign o_valid   = send;
    assign o_busy    = send;
    assign o_last    = last_word;
    assign o_data    = send ? buf_mem[idx_q] : '0;
    assign o_row     = row_q;
    assign o_col     = col_q;
    assign o_overrun = overrun_q;

endmodule
